// File: rtl/launch_pkg.sv
// Shared state type and parameter legality checks for the cannon launch controller.
package launch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHARGE = 3'd1,
    S_FULL   = 3'd2,
    S_PLAY   = 3'd3,
    S_COOL   = 3'd4
  } launch_state_t;

  function automatic bit launch_params_ok(input int levels, input int speed_w,
                                          input int ticks_per_level,
                                          input int hold_timeout, input int cooldown);
    return (levels >= 2) && (speed_w >= 1) && (speed_w < 31) &&
           ((1 << speed_w) >= levels) && (ticks_per_level >= 1) &&
           (hold_timeout >= 0) && (cooldown >= 0);
  endfunction

  // Counter width for a limit; a limit of 0 or 1 still needs one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/launch_charge_ctrl_if.sv
// Button/tick inputs and launch/HUD outputs of the cannon launch controller.
interface launch_charge_ctrl_if #(
  parameter int SPEED_W = 3
);
  logic               start;
  logic               tick;
  logic               rearm;
  logic [SPEED_W-1:0] startSpeed;
  logic               startGame;
  logic               cannon_load;
  logic               cannon_hold;
  logic [SPEED_W-1:0] level;
  logic               busy;

  modport master (
    output start, tick, rearm,
    input  startSpeed, startGame, cannon_load, cannon_hold, level, busy
  );

  modport slave (
    input  start, tick, rearm,
    output startSpeed, startGame, cannon_load, cannon_hold, level, busy
  );
endinterface

// File: rtl/tick_counter.sv
// Counts tick pulses and flags the LIMIT-th one; LIMIT of 0 never fires.
module tick_counter
  import launch_pkg::*;
#(
  parameter int LIMIT = 1
) (
  input  logic clk,
  input  logic resetN,
  input  logic tick,
  input  logic clr,
  output logic done
);

  localparam int CW = cnt_width(LIMIT);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (LIMIT != 0) && (cnt == CW'(LIMIT - 1));
  assign done    = tick && !clr && at_last;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (clr || done) begin
      cnt <= '0;
    end else if (tick && (LIMIT != 0)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/launch_charge_ctrl.sv
// Cannon charge-and-launch sequencer: charges while start is held, launches on
// release or after a hold timeout at full charge, then cools down before re-arming.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   S_IDLE   | waiting for a fresh press of start
//   S_CHARGE | start held, level climbing one step per level period
//   S_FULL   | start held at top level, hold timeout running
//   S_PLAY   | ball in flight, waiting for rearm
//   S_COOL   | cooldown ticks before returning to idle
module launch_charge_ctrl
  import launch_pkg::*;
#(
  parameter int LEVELS          = 5,
  parameter int SPEED_W         = 3,
  parameter int TICKS_PER_LEVEL = 1,
  parameter int HOLD_TIMEOUT    = 3,
  parameter int COOLDOWN        = 2
) (
  input logic                 clk,
  input logic                 resetN,
  launch_charge_ctrl_if.slave bus
);

  localparam logic [SPEED_W-1:0] TOP_LEVEL = SPEED_W'(LEVELS - 1);

  if (!launch_params_ok(LEVELS, SPEED_W, TICKS_PER_LEVEL, HOLD_TIMEOUT, COOLDOWN)) begin : g_bad_params
    $error("launch_charge_ctrl: illegal parameter set");
  end

  launch_state_t      state, state_nxt;
  logic               start_d;
  logic [SPEED_W-1:0] level_q, level_nxt;
  logic [SPEED_W-1:0] speed_q, speed_nxt;
  logic               game_q;
  logic               launch;
  logic               in_charge, in_full, in_cool;
  logic               lvl_done, hold_done, cool_done;

  assign in_charge = (state == S_CHARGE);
  assign in_full   = (state == S_FULL);
  assign in_cool   = (state == S_COOL);

  // Counters are held clear outside their own state, so each entry starts from zero.
  tick_counter #(.LIMIT(TICKS_PER_LEVEL)) u_level_cnt (
    .clk    (clk),
    .resetN (resetN),
    .tick   (bus.tick && in_charge && bus.start),
    .clr    (!in_charge),
    .done   (lvl_done)
  );

  tick_counter #(.LIMIT(HOLD_TIMEOUT)) u_hold_cnt (
    .clk    (clk),
    .resetN (resetN),
    .tick   (bus.tick && in_full && bus.start),
    .clr    (!in_full),
    .done   (hold_done)
  );

  tick_counter #(.LIMIT(COOLDOWN)) u_cool_cnt (
    .clk    (clk),
    .resetN (resetN),
    .tick   (bus.tick && in_cool),
    .clr    (!in_cool),
    .done   (cool_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level_q;
    speed_nxt = speed_q;
    launch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !start_d) begin
          state_nxt = S_CHARGE;
          level_nxt = '0;
        end
      end
      S_CHARGE: begin
        // Release beats a coincident tick: launch with the level before the step.
        if (!bus.start) begin
          launch    = 1'b1;
          speed_nxt = level_q;
        end else if (lvl_done && (level_q != TOP_LEVEL)) begin
          level_nxt = level_q + SPEED_W'(1);
          if (level_nxt == TOP_LEVEL) begin
            state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (!bus.start || hold_done) begin
          launch    = 1'b1;
          speed_nxt = TOP_LEVEL;
        end
      end
      S_PLAY: begin
        if (bus.rearm) begin
          state_nxt = (COOLDOWN == 0) ? S_IDLE : S_COOL;
        end
      end
      S_COOL: begin
        if (cool_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (launch) begin
      state_nxt = S_PLAY;
      level_nxt = '0;
    end
  end

  // start_d resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      start_d <= 1'b1;
      level_q <= '0;
      speed_q <= '0;
      game_q  <= 1'b0;
    end else begin
      start_d <= bus.start;
      level_q <= level_nxt;
      speed_q <= speed_nxt;
      game_q  <= launch;
    end
  end

  assign bus.startSpeed  = speed_q;
  assign bus.startGame   = game_q;
  assign bus.level       = level_q;
  assign bus.cannon_load = in_charge;
  assign bus.cannon_hold = in_full;
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: doc/launch_charge_ctrl.md
# launch_charge_ctrl

Parametrised cannon charge-and-launch controller for the ball game. While the player holds `start`, the cannon charges through `LEVELS` speed levels, one step per `TICKS_PER_LEVEL` ticks. It launches on release, or automatically after a hold timeout at full charge. After each round it runs a cooldown before it can be re-armed. It sits between the button debouncer / one-second tick generator and the ball movement and cannon drawing blocks.

## Interface
- `LEVELS`, 5, number of charge levels, ≥2; the launch speed is 0..`LEVELS`-1.
- `SPEED_W`, 3, width of the speed and level outputs; must satisfy 2^`SPEED_W` ≥ `LEVELS`.
- `TICKS_PER_LEVEL`, 1, number of `tick` pulses per level step, ≥1.
- `HOLD_TIMEOUT`, 3, number of ticks at full charge before auto-launch; 0 disables auto-launch.
- `COOLDOWN`, 2, number of ticks spent in cooldown after `rearm`; 0 means return to idle directly.
- `clk` in 1 system clock.
- `resetN` in 1 asynchronous active-low reset.
- `start` in 1 launch button, level-sensitive, already debounced.
- `tick` in 1 one-cycle timing pulse (oneSec class).
- `rearm` in 1 one-cycle pulse at end of round (ball lost).
- `startSpeed` out `SPEED_W` launch speed; latched at launch and held until the next launch.
- `startGame` out 1 one-cycle launch pulse.
- `cannon_load` out 1 high while charging.
- `cannon_hold` out 1 high while at full charge.
- `level` out `SPEED_W` current charge level, for the HUD.
- `busy` out 1 high in every state except S_IDLE.

Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `resetN`).

## Operation
- States: S_IDLE, S_CHARGE, S_FULL, S_PLAY, S_COOL.
- S_IDLE:
  - A rising edge of `start` (`start`=1 with registered `start_d`=0) moves to S_CHARGE. It clears `level` and the tick counter.
- S_CHARGE:
  - `start`=0 causes a launch with speed = `level`, then S_PLAY.
  - Otherwise each `tick` increments the tick counter. On the `TICKS_PER_LEVEL`-th tick, `level`++ and the counter clears.
  - When `level` reaches `LEVELS`-1 the block moves to S_FULL and clears the tick counter.
- S_FULL:
  - `start`=0 causes a launch with speed = `LEVELS`-1.
  - If `HOLD_TIMEOUT`≠0, each `tick` increments the timeout counter. On the `HOLD_TIMEOUT`-th tick the block auto-launches with speed = `LEVELS`-1.
- Launch: `startSpeed` ← speed, `startGame` pulses once, `level` ← 0, next state S_PLAY.
- S_PLAY:
  - `rearm` moves to S_COOL, or to S_IDLE if `COOLDOWN`=0. All other inputs are ignored.
- S_COOL:
  - Counts `COOLDOWN` ticks, then moves to S_IDLE. `start` is ignored.
- Outputs: `cannon_load` = (state==S_CHARGE); `cannon_hold` = (state==S_FULL). Both are decoded from the state register only.
- Simultaneous events:
  - Release and `tick` in the same cycle in S_CHARGE: the launch wins, with the pre-increment level.
  - Release and timeout in the same cycle in S_FULL: exactly one launch.
  - `rearm` outside S_PLAY is ignored.
- A button held through S_COOL → S_IDLE does not start a charge. A fresh press is required.
- Counter widths are sized with `$clog2`. The level increment never exceeds `LEVELS`-1.

## Timing
- Reset values: state S_IDLE, `startSpeed`=0, `startGame`=0, `level`=0, all counters 0, `start_d`=1. With `start_d`=1, a button held across reset release must be released before charging can begin.
- Every state transition takes effect at the edge that samples the triggering input. Moore outputs change in the following cycle.
- Launch decision sampled at edge k: `startGame`=1 and the new `startSpeed` are visible from edge k for exactly one cycle of `startGame`.
- Level update: `level` is visible one cycle after the qualifying `tick` edge.
- Reset asserted mid-charge or mid-cooldown: the block returns to S_IDLE immediately and no `startGame` is produced.

## Structure
- Package `launch_pkg`: typedef `launch_state_t` (enum logic [2:0]) and a parameter-legality check function.
- Sub-module `tick_counter`:
  - Parameter `LIMIT`; inputs `tick`, `clr`; output `done`.
  - `done` pulses on the `LIMIT`-th tick.
  - Instantiated three times: level step, hold timeout, cooldown.
- The top-level holds the FSM, the `start_d` register and the output registers.

## Test plan
- Defaults. Press `start`, give 2 ticks, release → `startGame` pulses once with `startSpeed`=2, then S_PLAY.
- Defaults. Hold through 4 ticks → `cannon_hold`=1, `level`=4. Give 3 more ticks without release → auto-launch with `startSpeed`=4. Releasing afterwards produces no second pulse.
- `TICKS_PER_LEVEL`=3. Hold for 5 ticks, release → `startSpeed`=1.
- Release coincident with `tick` while `level`=1 → `startSpeed`=1, not 2.
- In S_PLAY, pulse `rearm` while holding `start` through 2 cooldown ticks → S_IDLE with no charge. Release then press → S_CHARGE.
- Assert `resetN`=0 in S_CHARGE at `level`=3 → all outputs 0 immediately. `start` held across reset release produces no charge until it is re-pressed.
